// File: rtl/muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master = issuing stage, slave = muldiv_unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_op1;
  logic [XLEN-1:0]  in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_op1, in_op2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_op1, in_op2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring-divide step per cycle,
// signed ops run on magnitudes with the sign applied as the result is captured.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // hi/lo hold {product high, multiplier} or {partial remainder, dividend/quotient}
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic             is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d;

  logic             accept;
  logic             op1_neg, op2_neg, div_by_zero, overflow;
  logic [XLEN-1:0]  mag1, mag2, special_res;
  logic [XLEN:0]    mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [XLEN-1:0]  iter_hi, iter_lo, div_raw, div_res, mul_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    op1_neg = bus.in_op1[XLEN-1] &&
              (bus.in_op == OP_MULH || bus.in_op == OP_MULHSU ||
               bus.in_op == OP_DIV  || bus.in_op == OP_REM);
    op2_neg = bus.in_op2[XLEN-1] &&
              (bus.in_op == OP_MULH || bus.in_op == OP_DIV || bus.in_op == OP_REM);
    mag1 = op1_neg ? -bus.in_op1 : bus.in_op1;
    mag2 = op2_neg ? -bus.in_op2 : bus.in_op2;

    div_by_zero = bus.in_op[2] && (bus.in_op2 == '0);
    overflow    = (bus.in_op == OP_DIV || bus.in_op == OP_REM) &&
                  (bus.in_op1 == INT_MIN) && (bus.in_op2 == '1);
    if (div_by_zero) special_res = bus.in_op[1] ? bus.in_op1 : '1;
    else             special_res = bus.in_op[1] ? '0 : bus.in_op1;
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ok    = !div_diff[XLEN];

    if (is_div_q) begin
      iter_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      iter_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod     = {iter_hi, iter_lo};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    div_raw  = sel_hi_q ? iter_hi : iter_lo;
    div_res  = neg_q ? -div_raw : div_raw;
  end

  // NOTE: every *_d starts from its *_q so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mcand_d      = mcand_q;
    is_div_d     = is_div_q;
    sel_hi_d     = sel_hi_q;
    neg_d        = neg_q;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          out_tag_d = bus.in_tag;
          is_div_d  = bus.in_op[2];
          sel_hi_d  = bus.in_op[2] ? bus.in_op[1] : (bus.in_op[1:0] != 2'b00);
          neg_d     = (bus.in_op[2] && bus.in_op[1]) ? op1_neg : (op1_neg ^ op2_neg);
          hi_d      = '0;
          lo_d      = bus.in_op[2] ? mag1 : mag2;
          mcand_d   = bus.in_op[2] ? mag2 : mag1;
          if (div_by_zero || overflow) begin
            out_result_d = special_res;
            state_d      = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          hi_d = iter_hi;
          lo_d = iter_lo;
          if (cnt_q == '0) begin
            out_result_d = is_div_q ? div_res : mul_res;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  // NOTE: the working registers are always reloaded on accept before they are read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    hi_q     <= hi_d;
    lo_q     <= lo_d;
    mcand_q  <= mcand_d;
    is_div_q <= is_div_d;
    sel_hi_q <= sel_hi_d;
    neg_q    <= neg_d;
  end

  assign bus.in_ready   = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a driver queues expected results, a monitor pops and
// compares them on every output handshake.
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT_N = XLEN + 1;
  localparam int LAT_S = 1;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        check("spurious_out", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("result", bus.out_result, e.result);
        check("tag", bus.out_tag, e.tag);
      end
    end
  end

  // Presents one op, waits for accept, then returns once out_valid is seen.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp,
                        input int exp_lat);
    int guard;
    int lat;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_op1   = a;
    bus.in_op2   = b;
    bus.in_tag   = tag;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_accept_wait"}, guard < 50, 1);
    sb.push_back('{result: exp, tag: tag});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom());
    bus.in_op1   = $urandom();
    bus.in_op2   = $urandom();
    bus.in_tag   = TAG_W'($urandom());
    if (exp_lat > 1) begin
      check({name, "_busy"}, bus.busy, 1);
      check({name, "_in_ready_low"}, bus.in_ready, 0);
    end
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_tag", bus.out_tag, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    run_op("mul",      MUL,    32'd123,        32'd7,          5'd3,  32'd861,        LAT_N);
    run_op("mul_neg",  MUL,    32'hFFFF_FFFD,  32'd5,          5'd4,  32'hFFFF_FFF1,  LAT_N);
    run_op("mulh",     MULH,   32'hFFFF_FFFE,  32'd2,          5'd5,  32'hFFFF_FFFF,  LAT_N);
    run_op("mulh_pos", MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF,  5'd6,  32'h3FFF_FFFF,  LAT_N);
    run_op("mulhu",    MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'hFFFF_FFFE,  LAT_N);
    run_op("mulhsu",   MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'hFFFF_FFFF,  LAT_N);
    run_op("mulhsu_b", MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'hFFFF_FFFF,  LAT_N);
    run_op("div",      DIV,    32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFD,  LAT_N);
    run_op("rem",      REM,    32'hFFFF_FFF9,  32'd2,          5'd11, 32'hFFFF_FFFF,  LAT_N);
    run_op("div_nd",   DIV,    32'd7,          32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD,  LAT_N);
    run_op("rem_nd",   REM,    32'd7,          32'hFFFF_FFFE,  5'd13, 32'd1,          LAT_N);
    run_op("divu",     DIVU,   32'd100,        32'd7,          5'd14, 32'd14,         LAT_N);
    run_op("remu",     REMU,   32'd100,        32'd7,          5'd15, 32'd2,          LAT_N);
    run_op("divu_big", DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          LAT_N);
    run_op("div_z",    DIV,    32'd5,          32'd0,          5'd17, 32'hFFFF_FFFF,  LAT_S);
    run_op("divu_z",   DIVU,   32'd5,          32'd0,          5'd18, 32'hFFFF_FFFF,  LAT_S);
    run_op("rem_z",    REM,    32'd5,          32'd0,          5'd19, 32'd5,          LAT_S);
    run_op("remu_z",   REMU,   32'd5,          32'd0,          5'd20, 32'd5,          LAT_S);
    run_op("div_ovf",  DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd21, 32'h8000_0000,  LAT_S);
    run_op("rem_ovf",  REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd22, 32'd0,          LAT_S);

    // Backpressure: result held while the consumer stalls, new requests refused.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_op("bp", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 32'hFFFF_FFFE, LAT_N);
    bus.in_valid = 1'b1;
    bus.in_op    = DIVU;
    bus.in_op1   = 32'd9;
    bus.in_op2   = 32'd3;
    bus.in_tag   = 5'd30;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_result", bus.out_result, 32'hFFFF_FFFE);
      check("bp_tag", bus.out_tag, 5'd23);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Flush ten edges into a DIVU: op dropped, unit idle immediately.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = DIVU;
    bus.in_op1   = 32'd100;
    bus.in_op2   = 32'd7;
    bus.in_tag   = 5'd24;
    check("flush_pre_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_out", bus.out_valid, 0);

    // Reset in the middle of a MUL: op discarded, outputs return to reset values.
    bus.in_valid = 1'b1;
    bus.in_op    = MUL;
    bus.in_op1   = 32'd123;
    bus.in_op2   = 32'd7;
    bus.in_tag   = 5'd25;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("midrst_busy_before", bus.busy, 1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result", bus.out_result, 0);
    check("midrst_tag", bus.out_tag, 0);
    rst_n = 1'b1;
    #1 check("midrst_in_ready_after", bus.in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_out", bus.out_valid, 0);

    run_op("after_rst", DIVU, 32'd100, 32'd7, 5'd26, 32'd14, LAT_N);
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);
    check("final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
